// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: forwards non-memory ops to writeback in one cycle and
// runs load/store req/ack transactions on the data-memory port, with a timeout watchdog.
module mem_access_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_W      = 3,
  parameter int CTRL_W     = 8,
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] controlSignals_in,
  input  logic [DATA_W-1:0] ALUData_in,
  input  logic [DATA_W-1:0] ReadData2_in,
  input  logic [REG_W-1:0]  WriteAdd_in,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] controlSignals_out,
  output logic [DATA_W-1:0] MemData_out,
  output logic [DATA_W-1:0] ALUData_out,
  output logic [REG_W-1:0]  WriteAdd_out,
  output logic              mem_err
);

  localparam int CNT_W      = $clog2(WAIT_LIMIT + 1);
  localparam int MEM_READ   = 0;
  localparam int MEM_WRITE  = 1;
  localparam int REG_WRITE  = 2;
  localparam int MEM_TO_REG = 3;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic [CTRL_W-1:0] hold_ctrl;
  logic [DATA_W-1:0] hold_addr;
  logic [REG_W-1:0]  hold_dest;
  logic [CNT_W-1:0]  wait_cnt;
  logic              is_mem_op;
  logic              wait_expired;
  logic [CTRL_W-1:0] abort_ctrl;

  assign is_mem_op    = controlSignals_in[MEM_READ] | controlSignals_in[MEM_WRITE];
  assign wait_expired = (wait_cnt == CNT_W'(WAIT_LIMIT - 1));
  assign stall_out    = (state == ACCESS);

  // An aborted load must not write a register: strip RegWrite and MemToReg.
  always_comb begin
    abort_ctrl             = hold_ctrl;
    abort_ctrl[REG_WRITE]  = 1'b0;
    abort_ctrl[MEM_TO_REG] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, and every register
  // (including the holding regs) is cleared by the async reset so a reset mid-transaction
  // drops mem_req at once and leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      hold_ctrl          <= '0;
      hold_addr          <= '0;
      hold_dest          <= '0;
      wait_cnt           <= '0;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= '0;
      wb_valid           <= 1'b0;
      controlSignals_out <= '0;
      MemData_out        <= '0;
      ALUData_out        <= '0;
      WriteAdd_out       <= '0;
      mem_err            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wb_valid           <= 1'b0;
          controlSignals_out <= '0;
          if (in_valid) begin
            if (is_mem_op) begin
              hold_ctrl <= controlSignals_in;
              hold_addr <= ALUData_in;
              hold_dest <= WriteAdd_in;
              mem_req   <= 1'b1;
              mem_we    <= controlSignals_in[MEM_WRITE];
              mem_addr  <= ALUData_in;
              mem_wdata <= ReadData2_in;
              wait_cnt  <= '0;
              state     <= ACCESS;
            end else begin
              wb_valid           <= 1'b1;
              controlSignals_out <= controlSignals_in;
              ALUData_out        <= ALUData_in;
              WriteAdd_out       <= WriteAdd_in;
              MemData_out        <= '0;
            end
          end
        end

        ACCESS: begin
          // An ack on the last permitted cycle still completes the transaction.
          if (mem_ack) begin
            mem_req            <= 1'b0;
            wb_valid           <= 1'b1;
            controlSignals_out <= hold_ctrl;
            ALUData_out        <= hold_addr;
            WriteAdd_out       <= hold_dest;
            MemData_out        <= mem_we ? '0 : mem_rdata;
            state              <= IDLE;
          end else if (wait_expired) begin
            mem_req            <= 1'b0;
            mem_err            <= 1'b1;
            wb_valid           <= 1'b1;
            controlSignals_out <= abort_ctrl;
            ALUData_out        <= hold_addr;
            WriteAdd_out       <= hold_dest;
            MemData_out        <= '0;
            state              <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized traffic,
// checked against a transaction-level model of what writeback should receive.
module tb_mem_access_stage;

  localparam int DATA_W     = 16;
  localparam int REG_W      = 3;
  localparam int CTRL_W     = 8;
  localparam int WAIT_LIMIT = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [CTRL_W-1:0] ctrl_in = '0;
  logic [DATA_W-1:0] alu_in = '0;
  logic [DATA_W-1:0] rd2_in = '0;
  logic [REG_W-1:0]  wa_in = '0;
  logic              stall_out, mem_req, mem_we, wb_valid, mem_err;
  logic [DATA_W-1:0] mem_addr, mem_wdata, md_out, alu_out;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic [CTRL_W-1:0] ctrl_out;
  logic [REG_W-1:0]  wa_out;

  mem_access_stage #(
    .DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W), .WAIT_LIMIT(WAIT_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .controlSignals_in(ctrl_in), .ALUData_in(alu_in), .ReadData2_in(rd2_in),
    .WriteAdd_in(wa_in), .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .controlSignals_out(ctrl_out), .MemData_out(md_out),
    .ALUData_out(alu_out), .WriteAdd_out(wa_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: last instruction delivered to writeback, and the sticky error flag.
  logic [DATA_W-1:0] exp_alu = '0;
  logic [DATA_W-1:0] exp_md  = '0;
  logic [REG_W-1:0]  exp_wa  = '0;
  bit                exp_err = 1'b0;
  bit                data_known = 1'b1;

  // One cycle with an optional non-memory instruction; starts and ends just after a negedge.
  task automatic alu_step(input logic v, input logic [CTRL_W-1:0] c,
                          input logic [DATA_W-1:0] a, input logic [REG_W-1:0] w);
    logic [CTRL_W-1:0] ec;
    in_valid = v; ctrl_in = c; alu_in = a; rd2_in = DATA_W'($urandom); wa_in = w;
    @(negedge clk);
    ec = v ? c : '0;
    if (v) begin
      exp_alu = a; exp_wa = w; exp_md = '0; data_known = 1'b1;
    end
    n_checks++;
    if (wb_valid !== v) begin
      n_fail++; $display("FAIL alu_wb_valid: got %b want %b", wb_valid, v);
    end
    n_checks++;
    if (ctrl_out !== ec) begin
      n_fail++; $display("FAIL alu_ctrl_out: got %h want %h", ctrl_out, ec);
    end
    n_checks++;
    if (stall_out !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL alu_no_stall: stall=%b req=%b want 0 0", stall_out, mem_req);
    end
    n_checks++;
    if (mem_err !== exp_err) begin
      n_fail++; $display("FAIL alu_mem_err: got %b want %b", mem_err, exp_err);
    end
    if (data_known) begin
      n_checks++;
      if (alu_out !== exp_alu || wa_out !== exp_wa || md_out !== exp_md) begin
        n_fail++;
        $display("FAIL alu_data: got alu=%h wa=%0d md=%h want alu=%h wa=%0d md=%h",
                 alu_out, wa_out, md_out, exp_alu, exp_wa, exp_md);
      end
    end
  endtask

  // Full load/store transaction; memory acks in ACCESS cycle ack_at (out of range = never).
  task automatic run_mem(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] r,
                         input logic [REG_W-1:0] w, input int ack_at);
    int                cyc;
    int                exp_cyc;
    bit                wr;
    bit                tmo;
    logic [CTRL_W-1:0] ec;
    wr  = c[1];
    tmo = (ack_at < 1 || ack_at > WAIT_LIMIT);
    exp_cyc = tmo ? WAIT_LIMIT : ack_at;
    in_valid = 1'b1; ctrl_in = c; alu_in = a; rd2_in = d; wa_in = w; mem_ack = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (stall_out === 1'b1 && cyc < WAIT_LIMIT + 4) begin
      cyc++;
      n_checks++;
      if (mem_req !== 1'b1 || mem_we !== wr || mem_addr !== a || mem_wdata !== d) begin
        n_fail++;
        $display("FAIL mem_request: got req=%b we=%b addr=%h wdata=%h want 1 %b %h %h",
                 mem_req, mem_we, mem_addr, mem_wdata, wr, a, d);
      end
      n_checks++;
      if (wb_valid !== 1'b0 || ctrl_out !== '0) begin
        n_fail++; $display("FAIL mem_wait_quiet: wb_valid=%b ctrl=%h want 0 00", wb_valid, ctrl_out);
      end
      if (cyc == ack_at) begin
        mem_ack = 1'b1; mem_rdata = r;
      end else begin
        mem_rdata = DATA_W'($urandom);
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    in_valid = 1'b0;
    if (tmo) exp_err = 1'b1;
    ec = tmo ? (c & 8'hF3) : c;
    n_checks++;
    if (cyc != exp_cyc) begin
      n_fail++; $display("FAIL mem_access_cycles: got %0d want %0d", cyc, exp_cyc);
    end
    n_checks++;
    if (wb_valid !== 1'b1 || ctrl_out !== ec) begin
      n_fail++; $display("FAIL mem_done: wb_valid=%b ctrl=%h want 1 %h", wb_valid, ctrl_out, ec);
    end
    n_checks++;
    if (mem_req !== 1'b0 || stall_out !== 1'b0 || mem_err !== exp_err) begin
      n_fail++;
      $display("FAIL mem_release: req=%b stall=%b err=%b want 0 0 %b",
               mem_req, stall_out, mem_err, exp_err);
    end
    if (!tmo) begin
      exp_alu = a; exp_wa = w; exp_md = wr ? '0 : r; data_known = 1'b1;
      n_checks++;
      if (alu_out !== exp_alu || wa_out !== exp_wa || md_out !== exp_md) begin
        n_fail++;
        $display("FAIL mem_data: got alu=%h wa=%0d md=%h want alu=%h wa=%0d md=%h",
                 alu_out, wa_out, md_out, exp_alu, exp_wa, exp_md);
      end
    end else begin
      data_known = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({stall_out, mem_req, mem_we, wb_valid, mem_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: stall=%b req=%b we=%b wb=%b err=%b want all 0",
               stall_out, mem_req, mem_we, wb_valid, mem_err);
    end
    n_checks++;
    if ({ctrl_out, md_out, alu_out, wa_out, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: ctrl=%h md=%h alu=%h wa=%0d addr=%h wdata=%h want all 0",
               ctrl_out, md_out, alu_out, wa_out, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu_op();
    alu_step(1'b1, 8'h04, 16'h1234, 3'd3);
    alu_step(1'b0, 8'h04, 16'hFFFF, 3'd7);
    alu_step(1'b1, 8'hF4, 16'h8001, 3'd6);
  endtask

  task automatic test_load();
    run_mem(8'h0D, 16'h0040, 16'h7777, 16'hBEEF, 3'd2, 3);
    alu_step(1'b0, '0, '0, '0);
  endtask

  task automatic test_store_then_alu();
    run_mem(8'h02, 16'h0010, 16'h00AA, 16'h5555, 3'd1, 1);
    alu_step(1'b1, 8'h04, 16'h0BAD, 3'd4);
  endtask

  task automatic test_boundaries();
    run_mem(8'h0D, 16'h0123, 16'h0000, 16'hCAFE, 3'd5, WAIT_LIMIT);
    run_mem(8'h07, 16'h0200, 16'h1357, 16'h9999, 3'd6, 2);
  endtask

  task automatic test_timeout();
    run_mem(8'h0D, 16'h0080, 16'h0000, 16'hDEAD, 3'd7, 0);
    alu_step(1'b0, '0, '0, '0);
  endtask

  task automatic test_spurious_ack();
    mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    alu_step(1'b0, '0, '0, '0);
    mem_ack = 1'b0;
    alu_step(1'b0, '0, '0, '0);
  endtask

  task automatic test_random_mix();
    logic [CTRL_W-1:0] c;
    int                ack_at;
    for (int i = 0; i < 40; i++) begin
      c = CTRL_W'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        c[1:0] = 2'($urandom_range(1, 3));
        ack_at = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, WAIT_LIMIT);
        run_mem(c, DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                REG_W'($urandom), ack_at);
      end else begin
        c[1:0] = 2'b00;
        alu_step(($urandom_range(0, 3) != 0), c, DATA_W'($urandom), REG_W'($urandom));
      end
    end
  endtask

  task automatic test_reset_mid_access();
    in_valid = 1'b1; ctrl_in = 8'h0D; alu_in = 16'h0300; rd2_in = '0; wa_in = 3'd2;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || stall_out !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_start: req=%b stall=%b want 1 1", mem_req, stall_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || stall_out !== 1'b0 || wb_valid !== 1'b0 || mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: req=%b stall=%b wb=%b err=%b want 0 0 0 0",
               mem_req, stall_out, wb_valid, mem_err);
    end
    in_valid = 1'b0;
    exp_err = 1'b0; exp_alu = '0; exp_wa = '0; exp_md = '0; data_known = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    alu_step(1'b0, '0, '0, '0);
    mem_ack = 1'b0;
    alu_step(1'b1, 8'h04, 16'h5A5A, 3'd5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store_then_alu();
    test_boundaries();
    test_timeout();
    test_spurious_ack();
    test_random_mix();
    test_reset_mid_access();
    alu_step(1'b0, '0, '0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
